uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_tx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART datapath controllers.
package uart_pkg;

   localparam int unsigned SR_WIDTH = 8;
   localparam int unsigned SR_IDX_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Place din[nbits-1:0] bit-reversed into the top of the result, zeros below,
   // so a shift-left register presents din[0] first on its MSB.
   function automatic logic [SR_WIDTH-1:0] bit_rev(input logic [SR_WIDTH-1:0] din,
                                                   input int unsigned         nbits);
      logic [SR_WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < SR_WIDTH; i++) begin
         if (i < nbits) begin
            r[SR_IDX_W'(SR_WIDTH - 1 - i)] = din[SR_IDX_W'(i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last clock of each bit. Shared between TX and RX controllers.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end,
   output logic bit_pre
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt;

   // Free-running bit counter, restarted by clear and wrapping at the bit end
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bit_end = (cnt == CNT_LAST);
   assign bit_pre = (cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte handshake, shift-register sequencing and
// serial framing (start, data LSB first, optional parity, stop).
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       busy,
   output logic       sr_load,
   output logic       sr_shift,
   output logic [7:0] sr_din,
   input  logic       sr_msb,
   output logic       tx_out
);

   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] SHIFT_LIM  = IDX_W'(DATA_BITS - 2);
   localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);

   // Parameter legality, checked at elaboration
   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_clks
         $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > SR_WIDTH) begin : g_bad_data
         $error("uart_tx_ctrl: DATA_BITS must be 5..8");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
      end
   endgenerate

   tx_state_e        state, state_next;
   logic [IDX_W-1:0] bit_idx, bit_idx_next;
   logic             stop_idx, stop_idx_next;
   logic             tx_out_next, tx_done_next;
   logic             sr_load_next, sr_shift_next;
   logic [7:0]       sr_din_next;
   logic             bit_end, bit_pre, baud_clear;

`ifdef UART_TX_PARITY_EN
   localparam logic [SR_WIDTH-1:0] DATA_MASK = SR_WIDTH'((1 << DATA_BITS) - 1);
   logic parity_q, parity_next;
`endif

   // Bit timer restarts on every state entry and is held while idle
   assign baud_clear = (state == IDLE) || (state_next != state);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clear  (baud_clear),
      .bit_end(bit_end),
      .bit_pre(bit_pre)
   );

   // Next-state and next-output decode. tx_out is captured from sr_msb at each
   // bit boundary and sr_shift is raised in that same edge, so the register
   // advances during the bit and the following bit is ready at the next
   // boundary. The final data bit needs no further shift.
   always_comb begin
      state_next    = state;
      bit_idx_next  = bit_idx;
      stop_idx_next = stop_idx;
      tx_out_next   = tx_out;
      tx_done_next  = 1'b0;
      sr_load_next  = 1'b0;
      sr_shift_next = 1'b0;
      sr_din_next   = sr_din;
`ifdef UART_TX_PARITY_EN
      parity_next   = parity_q;
`endif
      case (state)
         IDLE: begin
            tx_out_next = 1'b1;
            if (tx_valid && tx_ready) begin
               state_next    = START;
               sr_load_next  = 1'b1;
               sr_din_next   = bit_rev(tx_data, DATA_BITS);
               tx_out_next   = 1'b0;
               bit_idx_next  = '0;
               stop_idx_next = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_next   = ^(tx_data & DATA_MASK);
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_next    = DATA;
               bit_idx_next  = '0;
               tx_out_next   = sr_msb;
               sr_shift_next = 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next  = PARITY;
                  tx_out_next = parity_q;
`else
                  state_next  = STOP;
                  tx_out_next = 1'b1;
`endif
                  stop_idx_next = 1'b0;
               end else begin
                  bit_idx_next  = bit_idx + IDX_W'(1);
                  tx_out_next   = sr_msb;
                  sr_shift_next = (bit_idx < SHIFT_LIM);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next    = STOP;
               tx_out_next   = 1'b1;
               stop_idx_next = 1'b0;
            end
         end
`endif
         STOP: begin
            tx_out_next  = 1'b1;
            tx_done_next = bit_pre && (stop_idx == LAST_STOP);
            if (bit_end) begin
               if (stop_idx == LAST_STOP) begin
                  state_next = IDLE;
               end else begin
                  stop_idx_next = stop_idx + 1'b1;
               end
            end
         end
         default: begin
            state_next  = IDLE;
            tx_out_next = 1'b1;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         tx_out   <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
         sr_load  <= 1'b0;
         sr_shift <= 1'b0;
         sr_din   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         bit_idx  <= bit_idx_next;
         stop_idx <= stop_idx_next;
         tx_out   <= tx_out_next;
         tx_ready <= (state_next == IDLE);
         busy     <= (state_next != IDLE);
         tx_done  <= tx_done_next;
         sr_load  <= sr_load_next;
         sr_shift <= sr_shift_next;
         sr_din   <= sr_din_next;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_next;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: two instances (8N1 and 7-data/2-stop) at
// CLKS_PER_BIT=4, each feeding a loadable shift-left register model.
module tb_uart_tx_ctrl;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [7:0] a_data, a_din, a_sr;
   logic       a_valid, a_ready, a_done, a_busy, a_load, a_shift, a_msb, a_tx_out;
   logic [7:0] b_data, b_din, b_sr;
   logic       b_valid, b_ready, b_done, b_busy, b_load, b_shift, b_msb, b_tx_out;

   uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
      .tx_done(a_done), .busy(a_busy), .sr_load(a_load), .sr_shift(a_shift),
      .sr_din(a_din), .sr_msb(a_msb), .tx_out(a_tx_out));

   uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
      .tx_done(b_done), .busy(b_busy), .sr_load(b_load), .sr_shift(b_shift),
      .sr_din(b_din), .sr_msb(b_msb), .tx_out(b_tx_out));

   // External shift register models
   always_ff @(posedge clk) begin
      if (rst)          a_sr <= '0;
      else if (a_load)  a_sr <= a_din;
      else if (a_shift) a_sr <= {a_sr[6:0], 1'b0};
   end
   always_ff @(posedge clk) begin
      if (rst)          b_sr <= '0;
      else if (b_load)  b_sr <= b_din;
      else if (b_shift) b_sr <= {b_sr[6:0], 1'b0};
   end
   assign a_msb = a_sr[7];
   assign b_msb = b_sr[7];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // One vector: instance select, byte, expected line bits (bit 0 first on
   // the wire) and expected parallel load value.
   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [11:0] line;
      logic [7:0] din;
   } vec_t;

   vec_t vecs[8];

   // Send one frame and check it cycle by cycle. Entered and left at a
   // falling edge; on return the controller should be back in IDLE.
   task automatic run_frame(input int sel, input logic [7:0] data, input logic [11:0] line,
                            input logic [7:0] din, input logic keep, input logic [7:0] after,
                            input string tag);
      int dbits, total, bi, loads, shifts, mis;
      int load_bad, shift_bad, done_bad, busy_bad, ready_bad, both;
      logic o, l, s, d, bz, rd, exp_s;
      dbits = (sel != 0) ? 7 : 8;
      total = (1 + dbits + P + ((sel != 0) ? 2 : 1)) * C;
      loads = 0; shifts = 0; mis = 0;
      load_bad = 0; shift_bad = 0; done_bad = 0; busy_bad = 0; ready_bad = 0; both = 0;
      chk({tag, "_ready_before"}, int'((sel != 0) ? b_ready : a_ready), 1);
      if (sel != 0) begin b_data = data; b_valid = 1'b1; end
      else          begin a_data = data; a_valid = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      if (sel != 0) begin b_data = after; b_valid = keep; end
      else          begin a_data = after; a_valid = keep; end
      for (int c = 1; c <= total; c++) begin
         o  = (sel != 0) ? b_tx_out : a_tx_out;
         l  = (sel != 0) ? b_load   : a_load;
         s  = (sel != 0) ? b_shift  : a_shift;
         d  = (sel != 0) ? b_done   : a_done;
         bz = (sel != 0) ? b_busy   : a_busy;
         rd = (sel != 0) ? b_ready  : a_ready;
         bi = (c - 1) / C;
         if (c == 1) chk({tag, "_sr_din"}, int'((sel != 0) ? b_din : a_din), int'(din));
         if (o != line[4'(bi)]) mis++;
         if ((c % C) == 0) begin
            chk($sformatf("%s_bit%0d_wrong_cycles", tag, bi), mis, 0);
            mis = 0;
         end
         exp_s = (bi >= 1) && (bi <= dbits - 1) && (((c - 1) % C) == 0);
         if (l) loads++;
         if (s) shifts++;
         if (l != (c == 1)) load_bad++;
         if (s != exp_s) shift_bad++;
         if (d != (c == total)) done_bad++;
         if (!bz) busy_bad++;
         if (rd) ready_bad++;
         if (l && s) both++;
         @(negedge clk);
      end
      chk({tag, "_load_count"}, loads, 1);
      chk({tag, "_shift_count"}, shifts, dbits - 1);
      chk({tag, "_load_timing_bad"}, load_bad, 0);
      chk({tag, "_shift_timing_bad"}, shift_bad, 0);
      chk({tag, "_done_timing_bad"}, done_bad, 0);
      chk({tag, "_busy_low_cycles"}, busy_bad, 0);
      chk({tag, "_ready_high_cycles"}, ready_bad, 0);
      chk({tag, "_load_shift_overlap"}, both, 0);
      chk({tag, "_ready_after"}, int'((sel != 0) ? b_ready : a_ready), 1);
      chk({tag, "_busy_after"}, int'((sel != 0) ? b_busy : a_busy), 0);
      chk({tag, "_line_idle_after"}, int'((sel != 0) ? b_tx_out : a_tx_out), 1);
   endtask

   initial begin
      int idle_bad;
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{0, 8'hA5, 12'h54A, 8'hA5};
      vecs[1] = '{0, 8'h00, 12'h400, 8'h00};
      vecs[2] = '{0, 8'hFF, 12'h5FE, 8'hFF};
      vecs[3] = '{0, 8'h12, 12'h424, 8'h48};
      vecs[4] = '{0, 8'h07, 12'h60E, 8'hE0};
      vecs[5] = '{0, 8'h01, 12'h602, 8'h80};
      vecs[6] = '{1, 8'h7F, 12'h7FE, 8'hFE};
      vecs[7] = '{1, 8'h85, 12'h60A, 8'hA0};
`else
      vecs[0] = '{0, 8'hA5, 12'h34A, 8'hA5};
      vecs[1] = '{0, 8'h00, 12'h200, 8'h00};
      vecs[2] = '{0, 8'hFF, 12'h3FE, 8'hFF};
      vecs[3] = '{0, 8'h12, 12'h224, 8'h48};
      vecs[4] = '{0, 8'h07, 12'h20E, 8'hE0};
      vecs[5] = '{0, 8'h01, 12'h202, 8'h80};
      vecs[6] = '{1, 8'h7F, 12'h3FE, 8'hFE};
      vecs[7] = '{1, 8'h85, 12'h30A, 8'hA0};
`endif
      rst = 1'b1;
      a_valid = 1'b0; a_data = '0;
      b_valid = 1'b0; b_data = '0;
      repeat (3) @(negedge clk);

      chk("rst_tx_out", int'(a_tx_out), 1);
      chk("rst_ready", int'(a_ready), 1);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_done", int'(a_done), 0);
      chk("rst_load", int'(a_load), 0);
      chk("rst_shift", int'(a_shift), 0);
      chk("rst_din", int'(a_din), 0);
      chk("rst_b_tx_out", int'(b_tx_out), 1);
      chk("rst_b_ready", int'(b_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // Table of single frames
      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].sel, vecs[i].data, vecs[i].line, vecs[i].din, 1'b0,
                   ~vecs[i].data, $sformatf("vec%0d", i));
      end

      // Back-to-back: valid held high across two frames and into the second;
      // the byte offered during the second frame must never be loaded.
      run_frame(0, 8'h00, vecs[1].line, 8'h00, 1'b1, 8'hFF, "b2b_first");
      run_frame(0, 8'hFF, vecs[2].line, 8'hFF, 1'b1, 8'h55, "b2b_second");
      a_valid = 1'b0;
      idle_bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (!a_ready || a_busy || a_load || !a_tx_out) idle_bad++;
      end
      chk("busy_valid_ignored", idle_bad, 0);

      // Reset landing on the START->DATA edge, where a shift and a low data
      // bit would otherwise be issued
      a_data = 8'h5A; a_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      repeat (C - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx_out", int'(a_tx_out), 1);
      chk("midrst_ready", int'(a_ready), 1);
      chk("midrst_busy", int'(a_busy), 0);
      chk("midrst_load", int'(a_load), 0);
      chk("midrst_shift", int'(a_shift), 0);
      chk("midrst_done", int'(a_done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_frame(0, 8'hA5, vecs[0].line, 8'hA5, 1'b0, 8'h00, "after_rst");

      // Reset coinciding with an acceptance edge wins over the handshake
      a_data = 8'h33; a_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      chk("rst_accept_load", int'(a_load), 0);
      chk("rst_accept_ready", int'(a_ready), 1);
      chk("rst_accept_tx_out", int'(a_tx_out), 1);
      a_valid = 1'b0; rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
